fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS core: holds the PC, fetches one instruction word per request from instruction memory over a req/ack handshake, and presents it to the main and ALU decoders. The fetched instruction stays held until downstream signals completion. Completion is signalled by `advance`, which carries that instruction's branch and jump outcome. The next PC (sequential, branch or jump) is computed here, and retired instructions are counted.

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/ack channel plus the
// held-instruction / advance channel towards the decoders and PC logic.
// The master side is the fetch unit itself; the slave side is the memory
// and downstream decode/execute logic.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        instr_valid;

  logic        advance;
  logic        pcsrc;
  logic        jump;
  logic [31:0] signimm;

  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic [31:0] retired;

  modport master (
    output imem_req, imem_addr, instr, op, funct, instr_valid,
           pc, pcplus4, retired,
    input  imem_ack, imem_rdata, advance, pcsrc, jump, signimm
  );

  modport slave (
    input  imem_req, imem_addr, instr, op, funct, instr_valid,
           pc, pcplus4, retired,
    output imem_ack, imem_rdata, advance, pcsrc, jump, signimm
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per request over
// a req/ack handshake, keeps it until downstream signals advance, then
// moves to the sequential, branch or jump target and counts retirements.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         i_clk,
  input  logic         i_reset,
  fetch_unit_if.master bus
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;

  logic [31:0] w_pcplus4;
  logic [31:0] w_branchTarget;
  logic [31:0] w_jumpTarget;
  logic [31:0] w_nextPc;
  logic        w_fetchDone;
  logic        w_advanceDone;

  assign w_pcplus4      = r_pc + 32'd4;
  assign w_branchTarget = w_pcplus4 + (bus.signimm << 2);
  assign w_jumpTarget   = {w_pcplus4[31:28], r_instr[25:0], 2'b00};

  // Ack only counts while requesting; advance only counts while holding.
  assign w_fetchDone   = (r_state == FETCH) && bus.imem_ack;
  assign w_advanceDone = (r_state == HOLD) && bus.advance;

  // Next-PC select: jump beats a taken branch, which beats sequential.
  always_comb begin
    w_nextPc = w_pcplus4;
    if (bus.jump) begin
      w_nextPc = w_jumpTarget;
    end else if (bus.pcsrc) begin
      w_nextPc = w_branchTarget;
    end
  end

  // Fetch/hold sequencer; reset abandons any in-flight fetch or held word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= FETCH;
      r_pc      <= RESET_PC;
      r_instr   <= 32'd0;
      r_retired <= 32'd0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_fetchDone) begin
            r_instr <= bus.imem_rdata;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_advanceDone) begin
            r_pc      <= w_nextPc;
            r_retired <= r_retired + 32'd1;
            r_state   <= FETCH;
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // Request and valid are masked by reset so nothing leaks out mid-reset.
  assign bus.imem_req    = (r_state == FETCH) && !i_reset;
  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_state == HOLD) && !i_reset;

  assign bus.instr   = r_instr;
  assign bus.op      = r_instr[31:26];
  assign bus.funct   = r_instr[5:0];
  assign bus.pc      = r_pc;
  assign bus.pcplus4 = w_pcplus4;
  assign bus.retired = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetched words go into a scoreboard queue
// when handed to the DUT and are popped when the DUT presents them as valid.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int checksTotal  = 0;
  int checksPassed = 0;
  int checksFailed = 0;

  logic [31:0] expInstrQ[$];
  logic [31:0] modelPc;
  logic [31:0] modelRetired;
  logic [31:0] heldInstr;

  // One comparison: counts it and reports tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive every DUT input of the slave side in one go.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                               input logic adv, input logic jmp,
                               input logic src, input logic [31:0] imm);
    bus.imem_ack   = ack;
    bus.imem_rdata = rdata;
    bus.advance    = adv;
    bus.jump       = jmp;
    bus.pcsrc      = src;
    bus.signimm    = imm;
  endtask

  task automatic nextCycle;
    @(negedge clk);
  endtask

  task automatic settle;
    #1;
  endtask

  // Fetch one word with a number of ack-wait cycles; optionally assert
  // advance/jump/pcsrc during the waits, which must have no effect.
  task automatic fetchWord(input logic [31:0] word, input int waits,
                           input logic noisy);
    logic [31:0] exp;
    for (int w = 0; w < waits; w++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, noisy, noisy, noisy, 32'h0000_0100);
      settle();
      checkOutput("waitReq", 32'(bus.imem_req), 32'd1);
      checkOutput("waitAddr", bus.imem_addr, modelPc);
      checkOutput("waitValid", 32'(bus.instr_valid), 32'd0);
      nextCycle();
    end
    applyStimulus(1'b1, word, 1'b0, 1'b0, 1'b0, 32'd0);
    expInstrQ.push_back(word);
    settle();
    checkOutput("fetchReq", 32'(bus.imem_req), 32'd1);
    checkOutput("fetchAddr", bus.imem_addr, modelPc);
    checkOutput("fetchValid", 32'(bus.instr_valid), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    checkOutput("holdValid", 32'(bus.instr_valid), 32'd1);
    checkOutput("holdReq", 32'(bus.imem_req), 32'd0);
    if (expInstrQ.size() == 0) begin
      checksTotal++;
      checksFailed++;
      $error("[TB] FAIL scoreboard: observed instr %h expected none queued", bus.instr);
    end else begin
      exp = expInstrQ.pop_front();
      heldInstr = exp;
      checkOutput("instr", bus.instr, exp);
      checkOutput("op", 32'(bus.op), 32'(exp[31:26]));
      checkOutput("funct", 32'(bus.funct), 32'(exp[5:0]));
    end
  endtask

  // Complete the held instruction and check the PC it moves to.
  task automatic advanceWith(input logic jmp, input logic src,
                             input logic [31:0] imm, input logic [31:0] expNext);
    applyStimulus(1'b0, 32'd0, 1'b1, jmp, src, imm);
    settle();
    checkOutput("advPc", bus.pc, modelPc);
    checkOutput("advPcPlus4", bus.pcplus4, modelPc + 32'd4);
    nextCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    modelPc = expNext;
    modelRetired = modelRetired + 32'd1;
    checkOutput("nextPc", bus.pc, modelPc);
    checkOutput("nextAddr", bus.imem_addr, modelPc);
    checkOutput("nextReq", 32'(bus.imem_req), 32'd1);
    checkOutput("nextValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("retired", bus.retired, modelRetired);
  endtask

  // Hold advance low while ack pulses and branch inputs wiggle.
  task automatic heldStall(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      applyStimulus(k[0] == 1'b0, $urandom, 1'b0, 1'b1, 1'b1, $urandom);
      settle();
      checkOutput("stallInstr", bus.instr, heldInstr);
      checkOutput("stallPc", bus.pc, modelPc);
      checkOutput("stallRetired", bus.retired, modelRetired);
      checkOutput("stallReq", 32'(bus.imem_req), 32'd0);
      checkOutput("stallValid", 32'(bus.instr_valid), 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelPc      = RESET_PC;
    modelRetired = 32'd0;
    heldInstr    = 32'd0;
    reset        = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd0);
    nextCycle();
    nextCycle();

    // Reset state, with an ack present that must be ignored.
    checkOutput("rstValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rstReq", 32'(bus.imem_req), 32'd0);
    checkOutput("rstPc", bus.pc, RESET_PC);
    checkOutput("rstInstr", bus.instr, 32'd0);
    checkOutput("rstRetired", bus.retired, 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    checkOutput("postRstReq", 32'(bus.imem_req), 32'd1);
    checkOutput("postRstAddr", bus.imem_addr, RESET_PC);

    // Sequential run: addresses 0, 4, 8, 12; retired reaches 3.
    fetchWord(32'h0123_4820, 0, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, 32'h0000_0004);
    fetchWord(32'h0085_3022, 0, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, 32'h0000_0008);
    fetchWord(32'h00A6_3824, 0, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, 32'h0000_000C);
    checkOutput("retiredThree", bus.retired, 32'd3);

    // Three wait states with advance/jump asserted during FETCH, then jump to 0x40.
    fetchWord(32'h0800_0010, 3, 1'b1);
    advanceWith(1'b1, 1'b0, 32'd0, 32'h0000_0040);

    // Backward branch then forward branch from 0x40.
    fetchWord(32'h1000_FFFE, 0, 1'b0);
    advanceWith(1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0000_003C);
    fetchWord(32'h0000_0000, 0, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, 32'h0000_0040);
    fetchWord(32'h1000_0003, 0, 1'b0);
    advanceWith(1'b0, 1'b1, 32'h0000_0003, 32'h0000_0050);

    // Long branch into the 0x1000_0000 region.
    fetchWord(32'h1000_FFEB, 0, 1'b0);
    advanceWith(1'b0, 1'b1, 32'h03FF_FFEB, 32'h1000_0000);

    // Held stall, then jump and branch together: jump wins.
    fetchWord(32'h0800_0010, 0, 1'b0);
    heldStall(5);
    advanceWith(1'b1, 1'b1, 32'h0000_0005, 32'h1000_0040);

    // Branch to the top word, then sequential wrap to zero.
    fetchWord(32'h1000_FFEE, 0, 1'b0);
    advanceWith(1'b0, 1'b1, 32'h3BFF_FFEE, 32'hFFFF_FFFC);
    fetchWord(32'h0000_0020, 0, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, 32'h0000_0000);

    // Branch to 0x20 and hold there for the mid-operation reset.
    fetchWord(32'h1000_0007, 0, 1'b0);
    advanceWith(1'b0, 1'b1, 32'h0000_0007, 32'h0000_0020);
    fetchWord(32'h8C43_0004, 0, 1'b0);

    reset = 1'b1;
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0);
    settle();
    checkOutput("midRstValid", 32'(bus.instr_valid), 32'd0);
    checkOutput("midRstReq", 32'(bus.imem_req), 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    settle();
    modelPc      = RESET_PC;
    modelRetired = 32'd0;
    checkOutput("midRstRetired", bus.retired, 32'd0);
    checkOutput("midRstInstr", bus.instr, 32'd0);
    checkOutput("midRstAddr", bus.imem_addr, RESET_PC);
    checkOutput("midRstReqUp", 32'(bus.imem_req), 32'd1);
    checkOutput("midRstValidLow", 32'(bus.instr_valid), 32'd0);

    // Fetching restarts cleanly from the reset PC.
    fetchWord(32'h2008_0005, 1, 1'b0);
    advanceWith(1'b0, 1'b0, 32'd0, RESET_PC + 32'd4);

    checkOutput("queueEmpty", 32'(expInstrQ.size()), 32'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
